// File: rtl/crossing_rate_meter_pkg.sv
// Shared types and helpers for the crossing-rate meter: polarity state
// encoding and the saturating shift used to scale the crossing count.
package crossing_rate_meter_pkg;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        NEG     = 2'd1,
        POS     = 2'd2
    } pol_state_e;

    // Shift left at 64-bit width, then clamp to the largest out_bits-wide
    // unsigned value so overflow never wraps into a small ratio.
    function automatic logic [31:0] sat_shl(input logic [31:0] value,
                                            input int unsigned shift,
                                            input int unsigned out_bits);
        logic [63:0] wide;
        logic [63:0] limit;
        wide  = {32'd0, value} << shift;
        limit = (64'd1 << out_bits) - 64'd1;
        return (wide > limit) ? limit[31:0] : wide[31:0];
    endfunction

endpackage

// File: rtl/crossing_rate_meter_if.sv
// Sample-stream and ratio bundle between the audio source, the crossing-rate
// meter and the volume decision stage.
interface crossing_rate_meter_if
    import crossing_rate_meter_pkg::*;
#(
    parameter int VOL_BITS = 23,
    parameter int CPC_BITS = 15
);
    // Handshake: there is no ready. Every cycle with sample_valid high delivers
    // one accepted sample; vol_valid is a one-cycle pulse per accepted sample,
    // issued the cycle after it, with vol/cpc/cpc_en stable alongside it.
    logic                       sample_valid;
    logic signed [VOL_BITS-1:0] sample;
    logic signed [VOL_BITS-1:0] vol;
    logic                       vol_valid;
    logic [CPC_BITS-1:0]        cpc;
    logic                       cpc_en;
    pol_state_e                 dbg_state;

    modport master (
        output sample_valid, sample,
        input  vol, vol_valid, cpc, cpc_en, dbg_state
    );

    modport slave (
        input  sample_valid, sample,
        output vol, vol_valid, cpc, cpc_en, dbg_state
    );

endinterface

// File: rtl/crossing_rate_meter_hyst_crossing_detect.sv
// Polarity tracker with a symmetric hysteresis band; flags rising crossings
// (NEG to POS) combinationally for the sample currently being accepted.
module hyst_crossing_detect
    import crossing_rate_meter_pkg::*;
#(
    parameter int VOL_BITS = 23,
    parameter int HYST     = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid,
    input  logic signed [VOL_BITS-1:0] sample,
    output logic                       rise,
    output pol_state_e                 state_o
);

    localparam logic signed [VOL_BITS-1:0] THR_HI = VOL_BITS'(HYST);
    localparam logic signed [VOL_BITS-1:0] THR_LO = -THR_HI;

    pol_state_e state_q;
    pol_state_e state_d;
    logic       is_hi;
    logic       is_lo;

    assign is_hi   = (sample >= THR_HI);
    assign is_lo   = (sample <= THR_LO);
    assign state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNKNOWN;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving UNKNOWN never counts: the first polarity seen is not a crossing.
    always_comb begin
        state_d = state_q;
        rise    = 1'b0;
        if (valid) begin
            case (state_q)
                UNKNOWN: begin
                    if (is_hi) begin
                        state_d = POS;
                    end else if (is_lo) begin
                        state_d = NEG;
                    end
                end
                NEG: begin
                    if (is_hi) begin
                        state_d = POS;
                        rise    = 1'b1;
                    end
                end
                POS: begin
                    if (is_lo) begin
                        state_d = NEG;
                    end
                end
                default: begin
                    state_d = UNKNOWN;
                end
            endcase
        end
    end

endmodule

// File: rtl/crossing_rate_meter.sv
// Counts rising zero crossings over fixed windows of accepted samples and
// publishes the count as a fixed-point ratio, aligned with a registered sample.
module crossing_rate_meter
    import crossing_rate_meter_pkg::*;
#(
    parameter int VOL_BITS    = 23,
    parameter int CPC_BITS    = 15,
    parameter int NUM_DECIMAL = 8,
    parameter int WINDOW_LOG2 = 10,
    parameter int TARGET_LOG2 = 2,
    parameter int HYST        = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    crossing_rate_meter_if.slave bus
);

    localparam int unsigned CPC_SHIFT = NUM_DECIMAL - TARGET_LOG2;
    localparam int unsigned CPC_WIDTH = CPC_BITS;

    logic       rise;
    pol_state_e pol_state;

    logic [WINDOW_LOG2-1:0]     win_q;
    logic [WINDOW_LOG2-1:0]     win_d;
    logic [WINDOW_LOG2-1:0]     cross_q;
    logic [WINDOW_LOG2-1:0]     cross_d;
    logic [WINDOW_LOG2:0]       close_count;
    logic                       window_close;
    logic signed [VOL_BITS-1:0] vol_q;
    logic signed [VOL_BITS-1:0] vol_d;
    logic                       vol_valid_q;
    logic                       vol_valid_d;
    logic [CPC_BITS-1:0]        cpc_q;
    logic [CPC_BITS-1:0]        cpc_d;
    logic                       cpc_en_q;
    logic                       cpc_en_d;

    hyst_crossing_detect #(
        .VOL_BITS (VOL_BITS),
        .HYST     (HYST)
    ) u_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (bus.sample_valid),
        .sample  (bus.sample),
        .rise    (rise),
        .state_o (pol_state)
    );

    // One extra bit so a saturated counter plus the closing crossing still fits.
    assign close_count  = {1'b0, cross_q} + {{WINDOW_LOG2{1'b0}}, rise};
    assign window_close = bus.sample_valid && (win_q == {WINDOW_LOG2{1'b1}});

    always_comb begin
        win_d       = win_q;
        cross_d     = cross_q;
        vol_d       = vol_q;
        vol_valid_d = bus.sample_valid;
        cpc_d       = cpc_q;
        cpc_en_d    = cpc_en_q;
        if (bus.sample_valid) begin
            vol_d = bus.sample;
            win_d = win_q + WINDOW_LOG2'(1);
            if (window_close) begin
                // The closing crossing is folded into this ratio, not the next window.
                cross_d  = '0;
                cpc_d    = CPC_BITS'(sat_shl(32'(close_count), CPC_SHIFT, CPC_WIDTH));
                cpc_en_d = 1'b1;
            end else if (rise && (cross_q != {WINDOW_LOG2{1'b1}})) begin
                cross_d = cross_q + WINDOW_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= '0;
            cross_q     <= '0;
            vol_q       <= '0;
            vol_valid_q <= 1'b0;
            cpc_q       <= '0;
            cpc_en_q    <= 1'b0;
        end else begin
            win_q       <= win_d;
            cross_q     <= cross_d;
            vol_q       <= vol_d;
            vol_valid_q <= vol_valid_d;
            cpc_q       <= cpc_d;
            cpc_en_q    <= cpc_en_d;
        end
    end

    assign bus.vol       = vol_q;
    assign bus.vol_valid = vol_valid_q;
    assign bus.cpc       = cpc_q;
    assign bus.cpc_en    = cpc_en_q;
    assign bus.dbg_state = pol_state;

endmodule

// File: tb/tb_crossing_rate_meter.sv
// Bench for crossing_rate_meter: scenario table from the test plan, a reset
// mid-window sequence and random stimulus against a per-sample reference model.
module tb_crossing_rate_meter;
    import crossing_rate_meter_pkg::*;

    localparam int VOL_BITS    = 23;
    localparam int CPC_BITS    = 15;
    localparam int NUM_DECIMAL = 8;
    localparam int WINDOW_LOG2 = 10;
    localparam int TARGET_LOG2 = 2;
    localparam int HYST        = 64;
    localparam int WIN         = 1 << WINDOW_LOG2;
    localparam int CPC_MAX     = (1 << CPC_BITS) - 1;

    // Clock and reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    crossing_rate_meter_if #(.VOL_BITS(VOL_BITS), .CPC_BITS(CPC_BITS)) bus ();

    crossing_rate_meter #(
        .VOL_BITS    (VOL_BITS),
        .CPC_BITS    (CPC_BITS),
        .NUM_DECIMAL (NUM_DECIMAL),
        .WINDOW_LOG2 (WINDOW_LOG2),
        .TARGET_LOG2 (TARGET_LOG2),
        .HYST        (HYST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: samples accepted, awaiting their vol_valid pulse
    logic [VOL_BITS-1:0] exp_q[$];

    // Reference model: polarity 0 = unknown, -1 = negative, +1 = positive
    int                          m_pol;
    int                          m_cnt;
    int                          m_seen;
    int                          m_cpc;
    bit                          m_en;
    bit                          m_vv;
    logic signed [VOL_BITS-1:0]  m_vol;

    typedef struct {
        string name;
        int    amp;
        int    half;
        bit    start_neg;
        int    gap;
        int    n_acc;
        int    exp_cpc;
        bit    exp_en;
    } vec_t;

    vec_t vecs[7];

    task automatic check_val(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pol  = 0;
        m_cnt  = 0;
        m_seen = 0;
        m_cpc  = 0;
        m_en   = 1'b0;
        m_vv   = 1'b0;
        m_vol  = '0;
    endtask

    task automatic model_step(input bit v, input int s);
        int ratio;
        m_vv = v;
        if (v) begin
            m_vol = VOL_BITS'(s);
            if (s >= HYST) begin
                if (m_pol == -1) m_cnt++;
                m_pol = 1;
            end else if (s <= -HYST) begin
                m_pol = -1;
            end
            m_seen++;
            if (m_seen == WIN) begin
                ratio  = m_cnt * (2 ** (NUM_DECIMAL - TARGET_LOG2));
                m_cpc  = (ratio > CPC_MAX) ? CPC_MAX : ratio;
                m_en   = 1'b1;
                m_cnt  = 0;
                m_seen = 0;
            end
        end
    endtask

    function automatic int exp_state_code();
        if (m_pol == 1)  return int'(POS);
        if (m_pol == -1) return int'(NEG);
        return int'(UNKNOWN);
    endfunction

    task automatic check_outputs(input string tag);
        logic [VOL_BITS-1:0] e;
        check_val({tag, ":vol_valid"}, longint'(bus.vol_valid), longint'(m_vv));
        if (bus.vol_valid) begin
            if (exp_q.size() == 0) begin
                check_val({tag, ":sb_underflow"}, longint'(bus.vol_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check_val({tag, ":sb_vol"}, longint'($signed(bus.vol)), longint'($signed(e)));
            end
        end
        check_val({tag, ":vol"}, longint'($signed(bus.vol)), longint'(m_vol));
        check_val({tag, ":cpc"}, longint'(bus.cpc), longint'(m_cpc));
        check_val({tag, ":cpc_en"}, longint'(bus.cpc_en), longint'(m_en));
        check_val({tag, ":state"}, longint'(int'(bus.dbg_state)), longint'(exp_state_code()));
    endtask

    // Driver: present inputs for one cycle, then check just after the edge
    task automatic cycle(input bit v, input int s, input string tag);
        bus.sample_valid = v;
        bus.sample       = VOL_BITS'(s);
        if (v) exp_q.push_back(VOL_BITS'(s));
        model_step(v, s);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n            = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        model_reset();
        exp_q.delete();
        #1;
        check_outputs(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int wave(input int k, input int amp, input int half, input bit start_neg);
        bit second_half;
        second_half = ((k / half) % 2) == 1;
        return (second_half == start_neg) ? amp : -amp;
    endfunction

    initial begin
        int k;
        int s;
        bit v;

        vecs[0] = '{"nominal",  1000, 128, 1'b1, 0, 1024,   256, 1'b1};
        vecs[1] = '{"doubled",  1000,  64, 1'b1, 0, 2048,   512, 1'b1};
        vecs[2] = '{"sat_w1",   1000,   1, 1'b0, 0, 1024, 32704, 1'b1};
        vecs[3] = '{"sat_w2",   1000,   1, 1'b0, 0, 2048, 32767, 1'b1};
        vecs[4] = '{"hyst_rej",   50,   1, 1'b0, 0, 2048,     0, 1'b1};
        vecs[5] = '{"gapped",   1000, 128, 1'b1, 2, 1024,   256, 1'b1};
        vecs[6] = '{"partial",  1000, 128, 1'b1, 0, 1023,     0, 1'b0};

        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        model_reset();
        #2;

        // Scenario table
        for (int i = 0; i < 7; i++) begin
            do_reset({vecs[i].name, ":reset"});
            for (int j = 0; j < vecs[i].n_acc; j++) begin
                cycle(1'b1, wave(j, vecs[i].amp, vecs[i].half, vecs[i].start_neg), vecs[i].name);
                for (int g = 0; g < vecs[i].gap; g++) begin
                    cycle(1'b0, 0, vecs[i].name);
                end
            end
            check_val({vecs[i].name, ":final_cpc"}, longint'(bus.cpc), longint'(vecs[i].exp_cpc));
            check_val({vecs[i].name, ":final_en"}, longint'(bus.cpc_en), longint'(vecs[i].exp_en));
        end

        // Reset in the middle of a window after one full window has completed
        do_reset("midrst:pre");
        k = 0;
        for (int j = 0; j < WIN + 600; j++) begin
            cycle(1'b1, wave(k, 1000, 64, 1'b1), "midrst:run");
            k++;
        end
        check_val("midrst:en_before", longint'(bus.cpc_en), 1);
        do_reset("midrst:reset");
        check_val("midrst:vol_zero", longint'($signed(bus.vol)), 0);
        check_val("midrst:cpc_zero", longint'(bus.cpc), 0);
        check_val("midrst:en_zero", longint'(bus.cpc_en), 0);
        for (int j = 0; j < WIN - 1; j++) begin
            cycle(1'b1, wave(k, 1000, 64, 1'b1), "midrst:after");
            k++;
        end
        check_val("midrst:en_1023", longint'(bus.cpc_en), 0);
        cycle(1'b1, wave(k, 1000, 64, 1'b1), "midrst:close");
        check_val("midrst:cpc_first", longint'(bus.cpc), 512);
        check_val("midrst:en_first", longint'(bus.cpc_en), 1);

        // Random stimulus around the hysteresis edges, random valid duty
        do_reset("rand:reset");
        for (int j = 0; j < 4000; j++) begin
            v = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 7))
                0:       s = HYST;
                1:       s = -HYST;
                2:       s = HYST - 1;
                3:       s = -(HYST - 1);
                default: s = int'($urandom_range(0, 600)) - 300;
            endcase
            cycle(v, s, "rand");
        end
        check_val("rand:sb_drained", longint'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/crossing_rate_meter.md
# crossing_rate_meter

Upstream companion of the volume-output decision stage. It consumes the signed audio sample stream and measures the rate of rising zero crossings over fixed sample windows. It produces the unsigned fixed-point `cpc` ratio and its `cpc_en` qualifier, plus a registered copy of the sample (`vol`) that stays aligned with `cpc`. The decision stage scales `vol` from these outputs.

## Interface
- `VOL_BITS`, 23, sample width (signed two's complement)
- `CPC_BITS`, 15, width of `cpc` (unsigned)
- `NUM_DECIMAL`, 8, fractional bits of `cpc`; 1.0 = `1 << NUM_DECIMAL`
- `WINDOW_LOG2`, 10, window length = `2**WINDOW_LOG2` valid samples
- `TARGET_LOG2`, 2, crossings per window that map to `cpc` = 1.0; must be <= `NUM_DECIMAL`
- `HYST`, 64, hysteresis threshold magnitude in sample LSBs (positive)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sample_valid`  in  1  qualifies `sample`; any duty cycle, including every cycle
- `sample`  in  `VOL_BITS` signed  incoming audio sample
- `vol`  out  `VOL_BITS` signed  registered copy of the last accepted sample
- `vol_valid`  out  1  one-cycle pulse, one cycle after each accepted sample
- `cpc`  out  `CPC_BITS`  crossing-rate ratio, Q(`CPC_BITS-NUM_DECIMAL`).`NUM_DECIMAL`
- `cpc_en`  out  1  high once the first full window has completed

## Operation
- **No backpressure.** Every cycle with `sample_valid` = 1 is an accepted sample.
- **Polarity FSM.** States UNKNOWN, NEG, POS. It advances only on accepted samples.
  - UNKNOWN → POS if `sample >= HYST`; UNKNOWN → NEG if `sample <= -HYST`. Neither transition counts a crossing.
  - NEG → POS if `sample >= HYST`. This is a rising crossing: increment the crossing counter.
  - POS → NEG if `sample <= -HYST`. No count.
  - A sample with `-HYST < sample < HYST` holds the current state.
- **Crossing counter.** Width `WINDOW_LOG2` bits. Saturates at all-ones and never wraps.
- **Window counter.** Width `WINDOW_LOG2` bits. Increments on each accepted sample and wraps naturally.
  - The accepted sample that arrives while the counter equals `2**WINDOW_LOG2 - 1` closes the window.
  - Closing count = crossing counter plus any crossing produced by the closing sample itself.
  - `cpc` <= closing count `<< (NUM_DECIMAL - TARGET_LOG2)`. Compute at full width. If the result exceeds `2**CPC_BITS - 1`, saturate `cpc` to all-ones.
  - The crossing counter clears to 0. The closing sample's crossing is not carried into the next window.
  - `cpc_en` <= 1 and stays sticky until reset.
- **Persistence.** The FSM state carries across windows and is not reset at window boundaries. `cpc` holds between window closes.

## Timing
- **Reset values.** `vol` = 0, `vol_valid` = 0, `cpc` = 0, `cpc_en` = 0. FSM = UNKNOWN. Both counters = 0.
- **Latency.** One cycle from `sample`/`sample_valid` to `vol`/`vol_valid`.
- **Window close.** On the closing sample, the `cpc`/`cpc_en` update lands on the same clock edge as that sample's `vol`/`vol_valid`. The decision stage therefore sees the new ratio together with the closing sample.
- **Sustained rate.** One sample per cycle with no bubbles.
- **Idle cycles.** `sample_valid` = 0: no state changes, and `vol` holds.
- **Reset mid-window.** The partial window is discarded. `cpc_en` drops to 0 and stays 0 until a full window completes after reset is released.

## Structure
- **Shared package (audio mixer).** FSM state enum {UNKNOWN, NEG, POS} and a saturating left-shift helper function for `cpc`.
- **Sub-module `hyst_crossing_detect`.** Holds the polarity FSM. Inputs: `clk`, `rst_n`, `valid`, `sample`. Output: combinational `rise` pulse for the current accepted sample. The top level holds the counters, saturation and output registers.

## Test plan
- **Nominal ratio.** Square wave ±1000, period 256 samples, continuous valid → after the 1024th sample, `cpc` = 256 (1.0) and `cpc_en` rises on the same edge as `vol_valid`.
- **Doubled rate.** Period 128 → `cpc` = 512 from the second window on.
- **Saturation.** Alternating ±1000 every sample. First window = 511 crossings → `cpc` = 32704. Second window = 512 crossings → `cpc` = 32767 (saturated).
- **Hysteresis rejection.** Samples alternating ±50 → `cpc` = 0 after each window, while `cpc_en` = 1.
- **Gapped valid.** Period-256 square with `sample_valid` at 1/3 duty → `cpc` = 256. `vol` holds during gaps, and `vol_valid` pulses once per accepted sample.
- **Reset mid-window.** Assert `rst_n` low after 600 samples of a period-128 stream → all outputs 0 and `cpc_en` = 0. After release, `cpc_en` stays 0 until 1024 further accepted samples, and the first `cpc` is then 512 (initial UNKNOWN state does not count).
